rom_port_arbiter: RTL

Shares one simple-dual-port synchronous ROM/RAM instance (registered read, separate read and write addresses, one cycle read latency) between two read requesters, e.g. a coprocessor fetch unit and a data-table unit. It also passes a loader write stream into the same memory so ROM images can be downloaded at run time. It sits between the coprocessor cores and the memory wrapper instance, and replaces direct address wiring when two cores need the same table.

---
 rtl/rom_arb_pkg.sv | 7 +
 rtl/rom_port_arbiter_rr_pick2.sv | 12 +
 rtl/rom_port_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared read-FSM encoding, port indices and read latency for rom_port_arbiter.
package rom_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_e;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int RD_LAT = 3;
endpackage

// File: rtl/rom_port_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker; on contention the port not granted last wins.
module rr_pick2
  import rom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);
  assign grant_valid = |req;
  assign grant_idx = (&req) ? ~last_grant : req[PORT_B];
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one registered-read memory between two read ports and a loader write stream.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loading,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_q,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_q,
  output logic [ADDR_W-1:0] mem_rdaddress,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  state_e state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d;
  logic a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic grant_valid, grant_idx;
  // a port being acked this cycle is about to drop its req, so it must not be regranted
  rr_pick2 u_pick (
    .req        ({b_req & ~b_ack_q, a_req & ~a_ack_q}),
    .last_grant (last_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    rd_addr_d = rd_addr_q;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
    wren_d = wr_en;
    waddr_d = wr_addr;
    wdata_d = wr_data;
    case (state_q)
      IDLE: if (!loading && grant_valid) begin
        state_d = WAIT;
        gnt_d = grant_idx;
        rd_addr_d = grant_idx ? b_addr : a_addr;
      end
      WAIT: state_d = CAPTURE;
      CAPTURE: begin
        state_d = IDLE;
        last_d = gnt_q;
        a_ack_d = gnt_q == PORT_A;
        b_ack_d = gnt_q == PORT_B;
        a_data_d = (gnt_q == PORT_A) ? mem_q : a_data_q;
        b_data_d = (gnt_q == PORT_B) ? mem_q : b_data_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= PORT_A;
      last_q <= PORT_B;
      rd_addr_q <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
      wren_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      rd_addr_q <= rd_addr_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      wren_q <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign a_ack = a_ack_q;
  assign b_ack = b_ack_q;
  assign a_q = a_data_q;
  assign b_q = b_data_q;
  assign mem_rdaddress = rd_addr_q;
  assign mem_wraddress = waddr_q;
  assign mem_data = wdata_q;
  assign mem_wren = wren_q;
endmodule
